// File: rtl/inst_fetch_bridge_pkg.sv
// Shared defines for the instruction fetch bridge.
// Holds the bus-width constants, the line-fill length, and the fill FSM
// state encodings used by inst_fetch_bridge.
package inst_fetch_bridge_pkg;

  // Bus widths shared with the core.
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  // Bytes fetched per instruction word from the byte-wide memory.
  localparam int FILL_LEN = 4;

  // Fill FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Byte-wide external instruction memory bus.
//   mem_addr_o : byte address driven by the bridge
//   mem_rd_o   : read strobe driven by the bridge
//   mem_data_i : read byte, returned one cycle after its strobe
// Modports: master = bridge side, slave = memory side.
interface inst_fetch_bridge_if;
  import inst_fetch_bridge_pkg::*;

  logic [InstAddrBus-1:0] mem_addr_o;
  logic                   mem_rd_o;
  logic [7:0]             mem_data_i;

  modport master (
    output mem_addr_o,
    output mem_rd_o,
    input  mem_data_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_rd_o,
    output mem_data_i
  );

endinterface

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns 32-bit core fetches into four byte reads
// on an external byte-wide memory, caching the last fetched word in a
// one-entry line buffer.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active low
//   ce_i         : core fetch enable
//   pc_i         : core fetch address
//   inv_i        : invalidate the line buffer
//   inst_o       : fetched instruction (0 when not valid)
//   inst_valid_o : inst_o belongs to the current pc_i
//   stallreq_o   : fetch stall request
//   mem          : byte-wide memory bus (master side)
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   inv_i,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o,
  output logic                   stallreq_o,
  inst_fetch_bridge_if.master    mem
);

  logic [1:0]             state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [InstAddrBus-1:0] base_q, base_d;
  logic [InstAddrBus-1:0] tag_q, tag_d;
  logic                   tag_vld_q, tag_vld_d;
  logic [InstBus-1:0]     word_q, word_d;
  // Bytes 0..2 of the word being filled; byte 3 goes straight into word.
  logic [23:0]            fill_q, fill_d;

  logic hit;
  logic abort;
  logic in_rd;

  // Reset masks the hit so that outputs are quiet while rst is low, and
  // stallreq_o then simply follows ce_i.
  assign hit   = rst & ce_i & tag_vld_q & (pc_i == tag_q);
  assign abort = !ce_i || (pc_i != base_q);
  assign in_rd = rst && (state_q == ST_RD);

  assign inst_valid_o   = hit;
  assign inst_o         = hit ? word_q : '0;
  assign stallreq_o     = ce_i & !hit;
  assign mem.mem_rd_o   = in_rd;
  assign mem.mem_addr_o = in_rd ? (base_q + InstAddrBus'(cnt_q)) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    word_d    = word_q;
    fill_d    = fill_q;

    case (state_q)
      ST_IDLE: begin
        if (ce_i && !hit) begin
          base_d  = pc_i;
          cnt_d   = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        // Reads already issued are left to complete; their bytes are
        // simply never captured once we are back in IDLE.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // The byte returning now belongs to the read of the previous cycle.
          for (int k = 0; k < FILL_LEN - 1; k++) begin
            if (cnt_q == 2'(k + 1)) begin
              fill_d[8*k +: 8] = mem.mem_data_i;
            end
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(FILL_LEN - 1)) begin
            state_d = ST_LAST;
          end
        end
      end
      ST_LAST: begin
        state_d = ST_IDLE;
        if (!abort) begin
          word_d    = {mem.mem_data_i, fill_q};
          tag_d     = base_q;
          tag_vld_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Invalidate overrides a same-cycle buffer write.
    if (inv_i) begin
      tag_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      word_q    <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      word_q    <= word_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: a vector table for reset,
// cold miss and hit, followed by hand-written multi-cycle sequences.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic [31:0] pc_i;
  logic        inv_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  int n_cmp  = 0;
  int n_fail = 0;

  inst_fetch_bridge_if bus ();

  inst_fetch_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .pc_i         (pc_i),
    .inv_i        (inv_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o),
    .mem          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: fixed program bytes at 0x100, address hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: mem_byte = 8'h13;
      32'h101: mem_byte = 8'h05;
      32'h102: mem_byte = 8'h10;
      32'h103: mem_byte = 8'h00;
      default: mem_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    exp_word = {mem_byte(a + 32'd3), mem_byte(a + 32'd2),
                mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Byte-wide memory with one cycle read latency; junk when not strobed.
  always @(posedge clk) begin
    if (bus.mem_rd_o) bus.mem_data_i <= mem_byte(bus.mem_addr_o);
    else              bus.mem_data_i <= 8'hEE;
  end

  task automatic drive(input logic r, input logic c, input logic [31:0] p,
                       input logic v);
    @(posedge clk);
    #1;
    rst = r; ce_i = c; pc_i = p; inv_i = v;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic c, input logic [31:0] p);
    for (int i = 0; i < n; i++) drive(1'b1, c, p, 1'b0);
  endtask

  task automatic check(input string nm, input logic es, input logic ev,
                       input logic [31:0] ei, input logic er,
                       input logic [31:0] ea);
    n_cmp++;
    if (stallreq_o !== es || inst_valid_o !== ev || inst_o !== ei ||
        bus.mem_rd_o !== er || bus.mem_addr_o !== ea) begin
      n_fail++;
      $display("FAIL %s: got stall=%b valid=%b inst=%h rd=%b addr=%h, want stall=%b valid=%b inst=%h rd=%b addr=%h",
               nm, stallreq_o, inst_valid_o, inst_o, bus.mem_rd_o,
               bus.mem_addr_o, es, ev, ei, er, ea);
    end
  endtask

  typedef struct {
    string       nm;
    logic        r;
    logic        c;
    logic [31:0] p;
    logic        v;
    logic        es;
    logic        ev;
    logic [31:0] ei;
    logic        er;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst = 1'b0; ce_i = 1'b0; pc_i = '0; inv_i = 1'b0;

    //             name            rst  ce   pc       inv  stall vld inst          rd   addr
    tbl[0]  = '{"rst_idle",       1'b0,1'b0,32'h000,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0};
    tbl[1]  = '{"rst_stall_ce",   1'b0,1'b1,32'h100,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
    tbl[2]  = '{"cold_T",         1'b1,1'b1,32'h100,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
    tbl[3]  = '{"cold_T1",        1'b1,1'b1,32'h100,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h100};
    tbl[4]  = '{"cold_T2",        1'b1,1'b1,32'h100,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h101};
    tbl[5]  = '{"cold_T3",        1'b1,1'b1,32'h100,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h102};
    tbl[6]  = '{"cold_T4",        1'b1,1'b1,32'h100,1'b0,1'b1,1'b0,32'h0,        1'b1,32'h103};
    tbl[7]  = '{"cold_T5",        1'b1,1'b1,32'h100,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
    tbl[8]  = '{"cold_T6",        1'b1,1'b1,32'h100,1'b0,1'b0,1'b1,32'h00100513, 1'b0,32'h0};
    tbl[9]  = '{"hit_1",          1'b1,1'b1,32'h100,1'b0,1'b0,1'b1,32'h00100513, 1'b0,32'h0};
    tbl[10] = '{"hit_2",          1'b1,1'b1,32'h100,1'b0,1'b0,1'b1,32'h00100513, 1'b0,32'h0};
    tbl[11] = '{"hit_needs_ce",   1'b1,1'b0,32'h100,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0};
    tbl[12] = '{"hit_3",          1'b1,1'b1,32'h100,1'b0,1'b0,1'b1,32'h00100513, 1'b0,32'h0};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].p, tbl[i].v);
      check(tbl[i].nm, tbl[i].es, tbl[i].ev, tbl[i].ei, tbl[i].er, tbl[i].ea);
    end

    // Invalidate in the LAST cycle: no valid line, same PC re-fetched.
    drive(1'b1, 1'b1, 32'h300, 1'b0);
    check("inv_miss_T", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h300, 1'b0);
      check("inv_fill_addr", 1'b1, 1'b0, 32'h0, 1'b1, 32'h300 + i);
    end
    drive(1'b1, 1'b1, 32'h300, 1'b1);
    check("inv_last", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h300, 1'b0);
    check("inv_collision_miss", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h300, 1'b0);
    check("inv_refetch", 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    run(4, 1'b1, 32'h300);
    drive(1'b1, 1'b1, 32'h300, 1'b0);
    check("inv_refetch_hit", 1'b0, 1'b1, exp_word(32'h300), 1'b0, 32'h0);

    // Redirect to 0x200 two cycles into a fill of 0x400.
    drive(1'b1, 1'b1, 32'h400, 1'b0);
    check("redir_T", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h400, 1'b0);
    check("redir_T1", 1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    check("redir_T2", 1'b1, 1'b0, 32'h0, 1'b1, 32'h401);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    check("redir_abort", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    check("redir_new_fill", 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    run(4, 1'b1, 32'h200);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    check("redir_hit", 1'b0, 1'b1, exp_word(32'h200), 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h400, 1'b0);
    check("redir_old_not_cached", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Dropping ce_i during the fill aborts without touching the buffer.
    drive(1'b1, 1'b0, 32'h400, 1'b0);
    check("ce_drop_in_rd", 1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
    drive(1'b1, 1'b0, 32'h400, 1'b0);
    check("ce_abort_idle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    check("abort_keeps_buffer", 1'b0, 1'b1, exp_word(32'h200), 1'b0, 32'h0);

    // Reset in the middle of a fill of 0x500.
    drive(1'b1, 1'b1, 32'h500, 1'b0);
    run(2, 1'b1, 32'h500);
    drive(1'b0, 1'b1, 32'h500, 1'b0);
    check("rst_midfill_out", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h500, 1'b0);
    check("rst_midfill_idle", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h500, 1'b0);
    check("rst_refill", 1'b1, 1'b0, 32'h0, 1'b1, 32'h500);
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    check("rst_cleared_buffer", 1'b1, 1'b0, 32'h0, 1'b1, 32'h501);
    run(3, 1'b0, 32'h0);

    // Unaligned fetch with address wrap.
    drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    check("wrap_T", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
      check("wrap_addr", 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE + i);
    end
    run(1, 1'b1, 32'hFFFF_FFFE);
    drive(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    check("wrap_hit", 1'b0, 1'b1, exp_word(32'hFFFF_FFFE), 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_bridge.md
INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 SHALL have port `clk`, input, 1 bit: clock, all state updates on rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous reset, asserted when 0.
REQ-004 SHALL have port `ce_i`, input, 1 bit: core fetch enable.
REQ-005 SHALL have port `pc_i`, input, 32 bits: core fetch address.
REQ-006 SHALL have port `inv_i`, input, 1 bit: invalidate the line buffer.
REQ-007 SHALL have port `inst_o`, output, 32 bits: fetched instruction, fed to the core's instruction-data input.
REQ-008 SHALL have port `inst_valid_o`, output, 1 bit: `inst_o` belongs to the current `pc_i`.
REQ-009 SHALL have port `stallreq_o`, output, 1 bit: fetch stall request, to the stall controller.
REQ-010 SHALL have port `mem_addr_o`, output, 32 bits: byte address on the external byte-wide memory.
REQ-011 SHALL have port `mem_rd_o`, output, 1 bit: memory read strobe.
REQ-012 SHALL have port `mem_data_i`, input, 8 bits: read byte, valid exactly 1 cycle after its strobe.

Function
REQ-013 SHALL keep a one-entry line buffer: `tag` (32 b), `tag_vld`, `word` (32 b).
REQ-014 SHALL define `hit` = `ce_i` & `tag_vld` & (`pc_i` == `tag`), computed combinationally.
REQ-015 SHALL drive `inst_valid_o` = `hit`, `inst_o` = `word` when `hit`, else 0.
REQ-016 SHALL drive `stallreq_o` = `ce_i` & !`hit`, combinationally.
REQ-017 SHALL implement FSM states IDLE, RD, LAST.
REQ-018 In IDLE with `ce_i` & !`hit`, SHALL latch `base`=`pc_i`, clear `cnt`, and move to RD.
REQ-019 In RD, SHALL drive `mem_rd_o`=1 and `mem_addr_o`=`base`+`cnt` (mod 2^32); `cnt` SHALL increment 0..3.
REQ-020 In RD with `cnt`>0, SHALL capture `mem_data_i` into byte `cnt`-1 of the fill register.
REQ-021 On leaving RD with `cnt`=3, SHALL move to LAST.
REQ-022 In LAST, SHALL drive `mem_rd_o`=0, capture byte 3, write `word`, set `tag`=`base` and `tag_vld`=1, and return to IDLE.
REQ-023 SHALL assemble bytes little-endian: byte k -> `word`[8k+7:8k].
REQ-024 Timing: miss seen in cycle T -> reads at T+1..T+4, buffer written at the end of T+5, `inst_valid_o`=1 in T+6; `stallreq_o` high T..T+5.
REQ-025 Outside RD, SHALL hold `mem_rd_o`=0 and `mem_addr_o`=0.
REQ-026 In RD or LAST, if `ce_i`=0 or `pc_i`!=`base`, SHALL abort: go to IDLE next cycle with no buffer update.
REQ-027 Abort SHALL have no effect on reads already issued; returned bytes SHALL be ignored.
REQ-028 `inv_i`=1 SHALL clear `tag_vld` at the next edge; if this coincides with the LAST-state write, invalidate wins (`tag_vld`=0).
REQ-029 `inv_i` SHALL NOT abort an in-progress fill other than per REQ-028.
REQ-030 An unaligned `pc_i` SHALL be fetched bytewise from exactly `pc_i`, with no error flag.
REQ-031 Address wrap SHALL be mod 2^32 (`base`=0xFFFFFFFE reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1).

Reset
REQ-032 `rst`=0 at an edge SHALL set state=IDLE, `cnt`=0, `tag`=0, `tag_vld`=0, `word`=0, `base`=0.
REQ-033 Reset SHALL take priority over every other event, including a mid-fill cycle; the fill is discarded.
REQ-034 While in reset: `inst_o`=0, `inst_valid_o`=0, `mem_rd_o`=0, `mem_addr_o`=0; `stallreq_o` follows REQ-016 (=`ce_i`).

Structure
REQ-035 SHALL place FSM state encodings and the fill length constant (4) in the shared defines file, alongside the existing bus-width macros.
REQ-036 SHALL use `InstAddrBus`/`InstBus` widths from the shared defines.
REQ-037 SHALL be implemented as a single module with no sub-modules; the line buffer is inline registers.

Verification
REQ-038 Cold miss: reset, `ce_i`=1, `pc_i`=0x100, memory bytes 0x13,0x05,0x10,0x00 -> `mem_addr_o` 0x100..0x103 in T+1..T+4; `inst_o`=0x00100513 with `inst_valid_o`=1 at T+6; `stallreq_o` high for 6 cycles.
REQ-039 Hit: after the above, hold `pc_i`=0x100 -> `stallreq_o`=0 and `mem_rd_o`=0 every cycle.
REQ-040 Redirect mid-fill: change `pc_i` to 0x200 at T+2 -> abort, new fill from 0x200; `tag` never equals 0x100 data mismatched.
REQ-041 Invalidate collision: `inv_i`=1 in the LAST cycle -> `tag_vld`=0, miss re-fetch of the same PC follows.
REQ-042 Reset mid-fill: `rst`=0 at T+3 -> next cycle IDLE, `mem_rd_o`=0, `inst_valid_o`=0.
REQ-043 Wrap: `pc_i`=0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
